// File: rtl/soc_system_pll_pkg.sv
// ---------------------------------------------------------------------------
// soc_system_pll_pkg
// Shared definitions for the ADC PLL lock controller:
//   - pll_state_e : 2-bit state encoding (S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RUN)
//   - DEF_*       : default timing constants for the controller parameters
//   - max3()      : elaboration-time helper used to size the shared timer
// ---------------------------------------------------------------------------
package soc_system_pll_pkg;

  // Controller states. All four 2-bit codes are used.
  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } pll_state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 65535;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_CNT_W          = 8;

  // Largest of three integers; sizes the timer shared by all states.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    return m;
  endfunction

endpackage

// File: rtl/soc_system_sync_bit.sv
// ---------------------------------------------------------------------------
// soc_system_sync_bit
// Multi-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears the whole chain
//   d_i    : asynchronous input level
//   q_o    : synchronized level, STAGES clk_i edges behind d_i
// ---------------------------------------------------------------------------
module soc_system_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; the first flop may go metastable, later flops let it settle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/soc_system_adc_pll_lock_ctrl.sv
// ---------------------------------------------------------------------------
// soc_system_adc_pll_lock_ctrl
// Drives the ADC PLL reset, waits for lock, qualifies it as stable and then
// releases the ADC sampling reset. Lock loss, lock timeout or a software
// request send the controller back through a full PLL reset pulse.
// Ports:
//   clk           : 50 MHz reference clock (same as PLL refclk)
//   reset_n       : asynchronous active-low reset
//   pll_locked    : PLL lock indication, asynchronous to clk
//   sw_relock     : single-cycle request for a full re-acquisition
//   pll_rst       : PLL reset, active-high
//   adc_rst_n     : ADC logic reset, active-low, high only in RUN
//   lock_ok       : high only in RUN
//   timeout_err   : sticky flag, a lock wait timed out since reset_n
//   lock_loss_cnt : saturating count of lock losses seen in RUN
// ---------------------------------------------------------------------------
module soc_system_adc_pll_lock_ctrl
  import soc_system_pll_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             sw_relock,
  output logic             pll_rst,
  output logic             adc_rst_n,
  output logic             lock_ok,
  output logic             timeout_err,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int TMR_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  // Terminal timer values: each state lasts exactly N cycles, counted 0..N-1.
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             lk_s;
  pll_state_e       state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             pll_rst_q;
  logic             adc_rst_n_q;
  logic             lock_ok_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] loss_cnt_q;
  logic [CNT_W-1:0] loss_cnt_d;

  soc_system_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

  // Saturating increment of the lock-loss counter; it never wraps.
  always_comb begin
    if (loss_cnt_q == CNT_MAX) begin
      loss_cnt_d = loss_cnt_q;
    end else begin
      loss_cnt_d = loss_cnt_q + CNT_ONE;
    end
  end

  // Lock-acquisition FSM with one shared timer. Outputs are registered
  // together with the state so they always reflect the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_PLL_RST;
      tmr_q         <= TMR_ZERO;
      pll_rst_q     <= 1'b1;
      adc_rst_n_q   <= 1'b0;
      lock_ok_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      loss_cnt_q    <= {CNT_W{1'b0}};
    end else if (sw_relock) begin
      // Software request overrides everything, including a simultaneous
      // lock loss or timeout; in PLL_RST it restarts (stretches) the pulse.
      state_q     <= S_PLL_RST;
      tmr_q       <= TMR_ZERO;
      pll_rst_q   <= 1'b1;
      adc_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (tmr_q == RST_LAST) begin
            state_q   <= S_WAIT_LOCK;
            tmr_q     <= TMR_ZERO;
            pll_rst_q <= 1'b0;
          end else begin
            tmr_q     <= tmr_q + TMR_ONE;
            pll_rst_q <= 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          // Lock takes priority over a timeout on the same cycle.
          if (lk_s) begin
            state_q <= S_STABLE;
            tmr_q   <= TMR_ZERO;
          end else if (tmr_q == TO_LAST) begin
            state_q       <= S_PLL_RST;
            tmr_q         <= TMR_ZERO;
            pll_rst_q     <= 1'b1;
            timeout_err_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end
        S_STABLE: begin
          // A dropout goes back to waiting with a fresh timeout window,
          // without pulsing the PLL reset.
          if (!lk_s) begin
            state_q <= S_WAIT_LOCK;
            tmr_q   <= TMR_ZERO;
          end else if (tmr_q == STB_LAST) begin
            state_q     <= S_RUN;
            tmr_q       <= TMR_ZERO;
            adc_rst_n_q <= 1'b1;
            lock_ok_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            state_q     <= S_PLL_RST;
            tmr_q       <= TMR_ZERO;
            pll_rst_q   <= 1'b1;
            adc_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            loss_cnt_q  <= loss_cnt_d;
          end else begin
            tmr_q       <= TMR_ZERO;
            adc_rst_n_q <= 1'b1;
            lock_ok_q   <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_PLL_RST;
          tmr_q       <= TMR_ZERO;
          pll_rst_q   <= 1'b1;
          adc_rst_n_q <= 1'b0;
          lock_ok_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = pll_rst_q;
  assign adc_rst_n     = adc_rst_n_q;
  assign lock_ok       = lock_ok_q;
  assign timeout_err   = timeout_err_q;
  assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_soc_system_adc_pll_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_soc_system_adc_pll_lock_ctrl
// Self-checking bench: directed scenarios with hand-computed cycle numbers,
// then randomized lock/relock/reset traffic. A behavioural model tracks the
// phase and the cycles remaining in it and is compared every cycle.
// ---------------------------------------------------------------------------
module tb_soc_system_adc_pll_lock_ctrl;

  localparam int PRC  = 4;
  localparam int LT   = 32;
  localparam int SC   = 8;
  localparam int SYNC = 2;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          pll_locked = 1'b0;
  logic          sw_relock = 1'b0;
  logic          pll_rst;
  logic          adc_rst_n;
  logic          lock_ok;
  logic          timeout_err;
  logic [CW-1:0] lock_loss_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int cnum   = 0;
  int n_cmp_msgs = 0;
  bit cmp_en = 1'b0;

  soc_system_adc_pll_lock_ctrl #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .SYNC_STAGES   (SYNC),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .sw_relock    (sw_relock),
    .pll_rst      (pll_rst),
    .adc_rst_n    (adc_rst_n),
    .lock_ok      (lock_ok),
    .timeout_err  (timeout_err),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phase plus "cycles left" in it; lock seen by the controller is the
  // pll_locked level from SYNC edges earlier.
  typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN} mph_e;

  mph_e          m_ph;
  int            m_left;
  bit            m_terr;
  int            m_cnt;
  bit [SYNC-1:0] m_dly;

  always @(posedge clk or negedge reset_n) begin
    mph_e          ph;
    int            left;
    bit            terr;
    int            cnt;
    bit            lk;
    bit [SYNC-1:0] dly;
    if (!reset_n) begin
      m_ph   <= M_RST;
      m_left <= PRC;
      m_terr <= 1'b0;
      m_cnt  <= 0;
      m_dly  <= '0;
    end else begin
      ph   = m_ph;
      left = m_left;
      terr = m_terr;
      cnt  = m_cnt;
      dly  = m_dly;
      lk   = dly[SYNC-1];
      dly  = {dly[SYNC-2:0], pll_locked};
      if (sw_relock) begin
        ph = M_RST; left = PRC;
      end else begin
        case (ph)
          M_RST: begin
            left = left - 1;
            if (left == 0) begin ph = M_WAIT; left = LT; end
          end
          M_WAIT: begin
            if (lk) begin
              ph = M_STAB; left = SC;
            end else begin
              left = left - 1;
              if (left == 0) begin terr = 1'b1; ph = M_RST; left = PRC; end
            end
          end
          M_STAB: begin
            if (!lk) begin
              ph = M_WAIT; left = LT;
            end else begin
              left = left - 1;
              if (left == 0) ph = M_RUN;
            end
          end
          default: begin
            if (!lk) begin
              cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
              ph = M_RST; left = PRC;
            end
          end
        endcase
      end
      m_ph   <= ph;
      m_left <= left;
      m_terr <= terr;
      m_cnt  <= cnt;
      m_dly  <= dly;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [CW+3:0] got_v;
    logic [CW+3:0] exp_v;
    if (cmp_en) begin
      got_v = {pll_rst, adc_rst_n, lock_ok, timeout_err, lock_loss_cnt};
      exp_v = {m_ph == M_RST, m_ph == M_RUN, m_ph == M_RUN, m_terr, CW'(m_cnt)};
      n_chk++;
      if (got_v !== exp_v) begin
        if (n_cmp_msgs < 40)
          $display("FAIL model_cmp t=%0t {pll_rst,adc_rst_n,lock_ok,terr,cnt} got=%b expected=%b",
                   $time, got_v, exp_v);
        n_cmp_msgs++;
      end else begin
        n_pass++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    sw_relock  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnum    = 0;
  endtask

  task automatic adv_to(input int k);
    while (cnum < k) begin
      @(negedge clk);
      cnum++;
    end
  endtask

  task automatic wait_adc(input logic v, input int budget, input string nm);
    int k;
    k = 0;
    while (adc_rst_n !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(adc_rst_n), 32'(v));
  endtask

  // Asserts reset_n between clock edges and checks outputs without any edge.
  task automatic async_reset_check(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    chk({tag, "_pll_rst"},   32'(pll_rst),       32'd1);
    chk({tag, "_adc_rst_n"}, 32'(adc_rst_n),     32'd0);
    chk({tag, "_lock_ok"},   32'(lock_ok),       32'd0);
    chk({tag, "_terr"},      32'(timeout_err),   32'd0);
    chk({tag, "_cnt"},       32'(lock_loss_cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    logic lv;
    int exp_cnt;
    #1;
    reset_n = 1'b0;
    cmp_en  = 1'b1;
    #20;

    // Power-up, lock at cycle 10, loss in RUN, sw_relock racing a loss, saturation.
    do_reset();
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_adc", 32'(adc_rst_n), 32'd0);
    chk("rst_lock_ok", 32'(lock_ok), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_cnt", 32'(lock_loss_cnt), 32'd0);
    adv_to(3);  chk("pu_pll_rst_c3", 32'(pll_rst), 32'd1);
    adv_to(4);  chk("pu_pll_rst_c4", 32'(pll_rst), 32'd0);
    adv_to(10); pll_locked = 1'b1;
    adv_to(20); chk("pu_adc_c20", 32'(adc_rst_n), 32'd0);
    adv_to(21); chk("pu_adc_c21", 32'(adc_rst_n), 32'd1);
    chk("pu_lock_ok_c21", 32'(lock_ok), 32'd1);
    chk("pu_cnt", 32'(lock_loss_cnt), 32'd0);
    adv_to(30); pll_locked = 1'b0;
    adv_to(32); chk("loss_adc_c32", 32'(adc_rst_n), 32'd1);
    adv_to(33); chk("loss_adc_c33", 32'(adc_rst_n), 32'd0);
    chk("loss_pll_rst_c33", 32'(pll_rst), 32'd1);
    chk("loss_cnt_c33", 32'(lock_loss_cnt), 32'd1);
    adv_to(36); chk("loss_pll_rst_c36", 32'(pll_rst), 32'd1);
    adv_to(37); chk("loss_pll_rst_c37", 32'(pll_rst), 32'd0);
    adv_to(40); pll_locked = 1'b1;
    adv_to(50); chk("relock_adc_c50", 32'(adc_rst_n), 32'd0);
    adv_to(51); chk("relock_adc_c51", 32'(adc_rst_n), 32'd1);
    adv_to(60); pll_locked = 1'b0;
    adv_to(62); sw_relock = 1'b1;
    adv_to(63); sw_relock = 1'b0;
    chk("swr_pll_rst_c63", 32'(pll_rst), 32'd1);
    chk("swr_adc_c63", 32'(adc_rst_n), 32'd0);
    chk("swr_cnt_c63", 32'(lock_loss_cnt), 32'd1);
    pll_locked = 1'b1;
    adv_to(66); chk("swr_pll_rst_c66", 32'(pll_rst), 32'd1);
    adv_to(67); chk("swr_pll_rst_c67", 32'(pll_rst), 32'd0);
    for (int i = 0; i < 300; i++) begin
      wait_adc(1'b1, 60, "sat_reach_run");
      pll_locked = 1'b0;
      wait_adc(1'b0, 10, "sat_drop");
      exp_cnt = (i + 2 < CMAX) ? i + 2 : CMAX;
      chk("sat_cnt_step", 32'(lock_loss_cnt), 32'(exp_cnt));
      pll_locked = 1'b1;
    end
    chk("sat_cnt_final", 32'(lock_loss_cnt), 32'd255);

    // Repeated timeouts, then lock, one loss, and async reset mid-RUN.
    do_reset();
    adv_to(35); chk("to_terr_c35", 32'(timeout_err), 32'd0);
    adv_to(36); chk("to_terr_c36", 32'(timeout_err), 32'd1);
    chk("to_pll_rst_c36", 32'(pll_rst), 32'd1);
    adv_to(39); chk("to_pll_rst_c39", 32'(pll_rst), 32'd1);
    adv_to(40); chk("to_pll_rst_c40", 32'(pll_rst), 32'd0);
    adv_to(71); chk("to_pll_rst_c71", 32'(pll_rst), 32'd0);
    adv_to(72); chk("to_pll_rst_c72", 32'(pll_rst), 32'd1);
    adv_to(80); pll_locked = 1'b1;
    adv_to(90); chk("to_adc_c90", 32'(adc_rst_n), 32'd0);
    adv_to(91); chk("to_adc_c91", 32'(adc_rst_n), 32'd1);
    adv_to(95); pll_locked = 1'b0;
    adv_to(97); chk("to_adc_c97", 32'(adc_rst_n), 32'd1);
    adv_to(98); chk("to_adc_c98", 32'(adc_rst_n), 32'd0);
    chk("to_cnt_c98", 32'(lock_loss_cnt), 32'd1);
    pll_locked = 1'b1;
    wait_adc(1'b1, 40, "to_rerun");
    repeat (3) @(negedge clk);
    chk("midrun_pre_terr", 32'(timeout_err), 32'd1);
    chk("midrun_pre_lock_ok", 32'(lock_ok), 32'd1);
    async_reset_check("midrun");

    // Unstable lock: STABLE aborts, timeout window restarts from the dropout.
    do_reset();
    adv_to(10); pll_locked = 1'b1;
    adv_to(15); pll_locked = 1'b0;
    for (int k = 16; k < 50; k++) begin
      adv_to(k);
      chk("unst_adc_low", 32'(adc_rst_n), 32'd0);
      chk("unst_pll_rst_low", 32'(pll_rst), 32'd0);
    end
    adv_to(50); chk("unst_pll_rst_c50", 32'(pll_rst), 32'd1);
    chk("unst_terr_c50", 32'(timeout_err), 32'd1);

    // sw_relock inside PLL_RST stretches the pulse; async reset mid-STABLE.
    do_reset();
    adv_to(2); sw_relock = 1'b1;
    adv_to(3); sw_relock = 1'b0;
    adv_to(6); chk("stretch_pll_rst_c6", 32'(pll_rst), 32'd1);
    adv_to(7); chk("stretch_pll_rst_c7", 32'(pll_rst), 32'd0);
    adv_to(10); pll_locked = 1'b1;
    adv_to(16); chk("midstab_pre_pll_rst", 32'(pll_rst), 32'd0);
    async_reset_check("midstab");

    // Randomized traffic checked by the model every cycle.
    do_reset();
    for (int seg = 0; seg < 200; seg++) begin
      len = $urandom_range(1, 60);
      lv  = ($urandom_range(0, 3) != 0);
      pll_locked = lv;
      for (int j = 0; j < len; j++) begin
        sw_relock = ($urandom_range(0, 63) == 0);
        @(negedge clk);
      end
      sw_relock = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        #2;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
